// File: rtl/fp16_mac_ctrl.sv
// Sequencer for an fp16 multiply-accumulate datapath: walks N operand pairs through an
// external multiplier and adder, accumulates the sum and reports it with a done pulse.
module fp16_mac_ctrl #(
   parameter int ADDR_W  = 8,
   parameter int LEN_W   = 8,
   parameter int MUL_LAT = 1,
   parameter int ADD_LAT = 1
) (
   input  logic              CLK,
   input  logic              RESETn,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [15:0]       mem_a,
   input  logic [15:0]       mem_b,
   output logic [15:0]       mul_a,
   output logic [15:0]       mul_b,
   input  logic [15:0]       mul_out,
   output logic [15:0]       add_a,
   output logic [15:0]       add_b,
   input  logic [15:0]       add_out,
   output logic              busy,
   output logic              done,
   output logic [15:0]       result
);

   localparam int MAX_LAT = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, MWAIT, AWAIT, DONE} state_t;

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  idx_q, idx_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [15:0]       acc_q, acc_d;
   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [15:0]       mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   logic [15:0]       add_a_q, add_a_d, add_b_q, add_b_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic [15:0]       result_q, result_d;

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      idx_d     = idx_q;
      base_d    = base_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      rd_addr_d = rd_addr_q;
      mul_a_d   = mul_a_q;
      mul_b_d   = mul_b_q;
      add_a_d   = add_a_q;
      add_b_d   = add_b_q;
      result_d  = result_q;

      // abort freezes every datapath register and only forces the state home
      if (abort) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  len_d    = len;
                  base_d   = base_addr;
                  acc_d    = 16'h0000;
                  idx_d    = '0;
                  result_d = 16'h0000;
                  state_d  = (len == '0) ? DONE : FETCH;
               end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
               mul_a_d = mem_a;
               mul_b_d = mem_b;
               cnt_d   = '0;
               state_d = MWAIT;
            end
            MWAIT: begin
               if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
                  add_a_d = acc_q;
                  add_b_d = mul_out;
                  cnt_d   = '0;
                  state_d = AWAIT;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            AWAIT: begin
               if (cnt_q == CNT_W'(ADD_LAT - 1)) begin
                  acc_d = add_out;
                  cnt_d = '0;
                  if (idx_q == len_q - LEN_W'(1)) begin
                     state_d = DONE;
                  end else begin
                     idx_d   = idx_q + LEN_W'(1);
                     state_d = FETCH;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end

      // outputs are registered against the state being entered
      rd_en_d = (state_d == FETCH);
      if (state_d == FETCH) begin
         rd_addr_d = base_d + ADDR_W'(idx_d);
      end
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
      if (state_d == DONE) begin
         result_d = acc_d;
      end
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q   <= IDLE;
         len_q     <= '0;
         idx_q     <= '0;
         base_q    <= '0;
         cnt_q     <= '0;
         acc_q     <= 16'h0000;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         mul_a_q   <= 16'h0000;
         mul_b_q   <= 16'h0000;
         add_a_q   <= 16'h0000;
         add_b_q   <= 16'h0000;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= 16'h0000;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         base_q    <= base_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         mul_a_q   <= mul_a_d;
         mul_b_q   <= mul_b_d;
         add_a_q   <= add_a_d;
         add_b_q   <= add_b_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         result_q  <= result_d;
      end
   end

   assign rd_en   = rd_en_q;
   assign rd_addr = rd_addr_q;
   assign mul_a   = mul_a_q;
   assign mul_b   = mul_b_q;
   assign add_a   = add_a_q;
   assign add_b   = add_b_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign result  = result_q;

endmodule

// File: tb/tb_fp16_mac_ctrl.sv
// Directed bench for fp16_mac_ctrl: two instances (latencies 1/1 and 3/2) driven against
// a sync-RAM model and table-based fp16 multiplier/adder models with matching latency.
module tb_fp16_mac_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [15:0] ram_a [256];
   logic [15:0] ram_b [256];

   logic       start_r [2];
   logic       abort_r [2];
   logic [7:0] base_r  [2];
   logic [7:0] len_r   [2];

   wire        rd_en_w   [2];
   wire        busy_w    [2];
   wire        done_w    [2];
   wire [7:0]  rd_addr_w [2];
   wire [15:0] mul_a_w   [2];
   wire [15:0] mul_b_w   [2];
   wire [15:0] add_a_w   [2];
   wire [15:0] add_b_w   [2];
   wire [15:0] result_w  [2];

   // hand-computed fp16 products for the operand pairs used below
   function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
      case ({a, b})
         {16'h3C00, 16'h4000}: return 16'h4000;
         {16'h3C00, 16'h3C00}: return 16'h3C00;
         {16'hA800, 16'h0C00}: return 16'h8080;
         default:              return 16'hDEAD;
      endcase
   endfunction

   // hand-computed fp16 sums, keyed as {accumulator, product}
   function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
      case ({a, b})
         {16'h0000, 16'h4000}: return 16'h4000;
         {16'h0000, 16'h3C00}: return 16'h3C00;
         {16'h3C00, 16'h3C00}: return 16'h4000;
         {16'h4000, 16'h3C00}: return 16'h4200;
         {16'h4200, 16'h3C00}: return 16'h4400;
         {16'h0000, 16'h8080}: return 16'h8080;
         default:              return 16'hBEEF;
      endcase
   endfunction

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_u
      localparam int ML = (gi == 0) ? 1 : 3;
      localparam int AL = (gi == 0) ? 1 : 2;
      logic [15:0] mem_a, mem_b, mul_out, add_out;
      logic [15:0] mpipe [ML];
      logic [15:0] apipe [AL];

      always_ff @(posedge clk) begin
         if (rd_en_w[gi]) begin
            mem_a <= ram_a[rd_addr_w[gi]];
            mem_b <= ram_b[rd_addr_w[gi]];
         end
         mpipe[0] <= fmul(mul_a_w[gi], mul_b_w[gi]);
         for (int i = 1; i < ML; i++) mpipe[i] <= mpipe[i-1];
         apipe[0] <= fadd(add_a_w[gi], add_b_w[gi]);
         for (int i = 1; i < AL; i++) apipe[i] <= apipe[i-1];
      end

      // latency L: valid L cycles after the inputs change, i.e. L-1 register stages
      assign mul_out = (ML == 1) ? fmul(mul_a_w[gi], mul_b_w[gi]) : mpipe[(ML >= 2) ? ML - 2 : 0];
      assign add_out = (AL == 1) ? fadd(add_a_w[gi], add_b_w[gi]) : apipe[(AL >= 2) ? AL - 2 : 0];

      fp16_mac_ctrl #(
         .ADDR_W (8),
         .LEN_W  (8),
         .MUL_LAT(ML),
         .ADD_LAT(AL)
      ) u_dut (
         .CLK      (clk),
         .RESETn   (rst_n),
         .start    (start_r[gi]),
         .abort    (abort_r[gi]),
         .base_addr(base_r[gi]),
         .len      (len_r[gi]),
         .rd_en    (rd_en_w[gi]),
         .rd_addr  (rd_addr_w[gi]),
         .mem_a    (mem_a),
         .mem_b    (mem_b),
         .mul_a    (mul_a_w[gi]),
         .mul_b    (mul_b_w[gi]),
         .mul_out  (mul_out),
         .add_a    (add_a_w[gi]),
         .add_b    (add_b_w[gi]),
         .add_out  (add_out),
         .busy     (busy_w[gi]),
         .done     (done_w[gi]),
         .result   (result_w[gi])
      );
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_zero(input int u, input string tag);
      check({tag, "_mul_a"},  mul_a_w[u],  32'h0);
      check({tag, "_mul_b"},  mul_b_w[u],  32'h0);
      check({tag, "_add_a"},  add_a_w[u],  32'h0);
      check({tag, "_add_b"},  add_b_w[u],  32'h0);
      check({tag, "_result"}, result_w[u], 32'h0);
      check({tag, "_ctl"},    {rd_en_w[u], busy_w[u], done_w[u], rd_addr_w[u]}, 32'h0);
   endtask

   // One start, then watch up to 60 cycles; j counts cycles after the accepting edge.
   task automatic run(input int u, input string tag, input logic [7:0] b, input logic [7:0] n,
                      input logic [15:0] exp_res, input int exp_cyc, input int exp_nrd,
                      input int poke_start, input int poke_abort);
      int dcyc, nrd, pulse_bad, addr_bad;
      logic prev;
      logic [7:0] ea;
      dcyc = -1; nrd = 0; pulse_bad = 0; addr_bad = 0; prev = 1'b0;
      @(negedge clk);
      base_r[u]  = b;
      len_r[u]   = n;
      start_r[u] = 1'b1;
      @(negedge clk);
      start_r[u] = 1'b0;
      for (int j = 0; j < 60; j++) begin
         if (j > 0) @(negedge clk);
         if (rd_en_w[u] === 1'b1) begin
            ea = b + 8'(nrd);
            if (prev) pulse_bad++;
            if (rd_addr_w[u] !== ea) addr_bad++;
            nrd++;
         end
         prev = rd_en_w[u];
         if (poke_abort >= 0 && j == poke_abort + 1)
            check({tag, "_busy_after_abort"}, busy_w[u], 32'h0);
         start_r[u] = (j == poke_start);
         if (j == poke_start) begin
            base_r[u] = 8'h30;
            len_r[u]  = 8'd1;
         end
         abort_r[u] = (j == poke_abort);
         if (done_w[u] === 1'b1) begin
            dcyc = j;
            break;
         end
      end
      start_r[u] = 1'b0;
      abort_r[u] = 1'b0;
      $display("run %s: u=%0d done_cyc=%0d result=0x%04h reads=%0d", tag, u, dcyc, result_w[u], nrd);
      check({tag, "_done_cyc"}, dcyc, exp_cyc);
      check({tag, "_result"}, result_w[u], exp_res);
      check({tag, "_reads"}, nrd, exp_nrd);
      check({tag, "_addr_seq"}, addr_bad, 0);
      check({tag, "_rd_pulse"}, pulse_bad, 0);
      if (dcyc >= 0) begin
         @(negedge clk);
         check({tag, "_after_done"}, {done_w[u], busy_w[u], result_w[u]}, {2'b00, exp_res});
      end
   endtask

   initial begin
      int dn;
      rst_n = 1'b0;
      for (int i = 0; i < 256; i++) begin
         ram_a[i] = 16'h0000;
         ram_b[i] = 16'h0000;
      end
      ram_a[8'h10] = 16'h3C00; ram_b[8'h10] = 16'h4000;
      for (int i = 8'h20; i <= 8'h22; i++) begin
         ram_a[i] = 16'h3C00; ram_b[i] = 16'h3C00;
      end
      ram_a[8'h30] = 16'hA800; ram_b[8'h30] = 16'h0C00;
      ram_a[8'hFE] = 16'h3C00; ram_b[8'hFE] = 16'h3C00;
      ram_a[8'hFF] = 16'h3C00; ram_b[8'hFF] = 16'h3C00;
      ram_a[8'h00] = 16'h3C00; ram_b[8'h00] = 16'h3C00;
      ram_a[8'h01] = 16'h3C00; ram_b[8'h01] = 16'h3C00;
      for (int u = 0; u < 2; u++) begin
         start_r[u] = 1'b0; abort_r[u] = 1'b0; base_r[u] = 8'h00; len_r[u] = 8'h00;
      end

      repeat (3) @(negedge clk);
      check_zero(0, "reset_u0");
      check_zero(1, "reset_u1");
      rst_n = 1'b1;

      run(0, "n1_basic",     8'h10, 8'd1, 16'h4000,  4, 1, -1, -1);
      check("n1_mul_a", mul_a_w[0], 32'h3C00);
      check("n1_mul_b", mul_b_w[0], 32'h4000);
      check("n1_add_ab", {add_a_w[0], add_b_w[0]}, {16'h0000, 16'h4000});
      run(0, "n1_subnormal", 8'h30, 8'd1, 16'h8080,  4, 1, -1, -1);
      run(0, "n0",           8'h40, 8'd0, 16'h0000,  0, 0, -1, -1);
      run(0, "n3_ones",      8'h20, 8'd3, 16'h4200, 12, 3, -1, -1);
      run(0, "n4_wrap",      8'hFE, 8'd4, 16'h4400, 16, 4, -1, -1);
      run(0, "abort_mwait",  8'h20, 8'd3, 16'h0000, -1, 1, -1,  2);
      run(0, "after_abort",  8'h10, 8'd1, 16'h4000,  4, 1, -1, -1);
      run(0, "start_busy",   8'h20, 8'd3, 16'h4200, 12, 3,  5, -1);

      // reset asserted while the first element sits in AWAIT
      @(negedge clk);
      base_r[0] = 8'h10; len_r[0] = 8'd1; start_r[0] = 1'b1;
      @(negedge clk);
      start_r[0] = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mid_pre_busy", busy_w[0], 32'h1);
      check("rst_mid_pre_mul_b", mul_b_w[0], 32'h4000);
      rst_n = 1'b0;
      #1;
      check_zero(0, "rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      repeat (20) begin
         @(negedge clk);
         if (done_w[0] === 1'b1) dn++;
      end
      check("rst_mid_no_done", dn, 0);
      $display("run rst_mid: u=0 done_pulses_after_reset=%0d", dn);

      run(1, "lat32_n3", 8'h20, 8'd3, 16'h4200, 21, 3, -1, -1);
      run(1, "lat32_n1", 8'h10, 8'd1, 16'h4000,  7, 1, -1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
